// File: rtl/ahb_burst_addr_gen_pkg.sv
// Shared AHB burst/transfer types, HSIZE codes and burst-length / wrap-address helpers
// for the ahb_burst_addr_gen slice.
package ahb_pkg;

    typedef enum logic [2:0] {
        AHB_BURST_SINGLE = 3'd0,
        AHB_BURST_INCR   = 3'd1,
        AHB_BURST_WRAP4  = 3'd2,
        AHB_BURST_INCR4  = 3'd3,
        AHB_BURST_WRAP8  = 3'd4,
        AHB_BURST_INCR8  = 3'd5,
        AHB_BURST_WRAP16 = 3'd6,
        AHB_BURST_INCR16 = 3'd7
    } ahb_burst_type;

    typedef enum logic [1:0] {
        AHB_TRANS_IDLE   = 2'd0,
        AHB_TRANS_BUSY   = 2'd1,
        AHB_TRANS_NONSEQ = 2'd2,
        AHB_TRANS_SEQ    = 2'd3
    } ahb_trans_type;

    localparam logic [2:0] AHB_SIZE_BYTE   = 3'd0;
    localparam logic [2:0] AHB_SIZE_HALF   = 3'd1;
    localparam logic [2:0] AHB_SIZE_WORD   = 3'd2;
    localparam logic [2:0] AHB_SIZE_DWORD  = 3'd3;
    localparam logic [2:0] AHB_SIZE_QWORD  = 3'd4;
    localparam logic [2:0] AHB_SIZE_256    = 3'd5;
    localparam logic [2:0] AHB_SIZE_512    = 3'd6;
    localparam logic [2:0] AHB_SIZE_1024   = 3'd7;

    // Fixed-length beat count; undefined-length INCR reports 0 (length comes from the command).
    function automatic logic [4:0] get_burst_size(input logic [2:0] burst);
        logic [4:0] beats;
        case (burst)
            AHB_BURST_SINGLE:                  beats = 5'd1;
            AHB_BURST_WRAP4,  AHB_BURST_INCR4:  beats = 5'd4;
            AHB_BURST_WRAP8,  AHB_BURST_INCR8:  beats = 5'd8;
            AHB_BURST_WRAP16, AHB_BURST_INCR16: beats = 5'd16;
            default:                           beats = 5'd0;
        endcase
        return beats;
    endfunction

    // A wrap window is at most 16 beats * 128 bytes, so only the low 11 address bits move.
    function automatic logic [10:0] wrap_next_addr(input logic [10:0] addr,
                                                   input logic [2:0]  size,
                                                   input logic [4:0]  beats);
        logic [11:0] inc;
        logic [11:0] mask;
        logic [11:0] res;
        inc  = 12'd1 << size;
        mask = (12'(beats) << size) - 12'd1;
        res  = (12'(addr) & ~mask) | ((12'(addr) + inc) & mask);
        return res[10:0];
    endfunction

endpackage

// File: rtl/ahb_burst_addr_gen_if.sv
// Command and AHB address-phase bundle for ahb_burst_addr_gen; master = the sequencer side.
interface ahb_burst_addr_gen_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_W      = 5
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [2:0]            cmd_burst;
    logic [2:0]            cmd_size;
    logic                  cmd_write;
    logic [LEN_W-1:0]      cmd_len;
    logic                  HREADY;
    logic [1:0]            HTRANS;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [2:0]            HBURST;
    logic [2:0]            HSIZE;
    logic                  HWRITE;
    logic [LEN_W-1:0]      beat_idx;
    logic                  last_beat;
    logic                  cmd_err;

    modport master (
        input  cmd_valid, cmd_addr, cmd_burst, cmd_size, cmd_write, cmd_len, HREADY,
        output cmd_ready, HTRANS, HADDR, HBURST, HSIZE, HWRITE, beat_idx, last_beat, cmd_err
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_burst, cmd_size, cmd_write, cmd_len, HREADY,
        input  cmd_ready, HTRANS, HADDR, HBURST, HSIZE, HWRITE, beat_idx, last_beat, cmd_err
    );
endinterface

// File: rtl/ahb_burst_addr_gen_addr_step.sv
// Combinational next-beat address for incrementing and wrapping bursts.
// AHB_KB_BOUNDARY_EN enables detection of an incrementing step that crosses a 1 KB boundary.
module ahb_addr_step
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [2:0]            size_i,
    input  logic [2:0]            burst_i,
    output logic [ADDR_WIDTH-1:0] next_addr_o,
    output logic                  kb_cross_o
);
    logic [ADDR_WIDTH-1:0] inc;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic                  is_wrap;

    assign inc       = ADDR_WIDTH'(1) << size_i;
    assign incr_addr = addr_i + inc;
    assign is_wrap   = (burst_i == AHB_BURST_WRAP4) || (burst_i == AHB_BURST_WRAP8) ||
                       (burst_i == AHB_BURST_WRAP16);

    always_comb begin
        next_addr_o = incr_addr;
        if (is_wrap) begin
            next_addr_o       = addr_i;
            next_addr_o[10:0] = wrap_next_addr(addr_i[10:0], size_i, get_burst_size(burst_i));
        end
    end

`ifdef AHB_KB_BOUNDARY_EN
    // Odd burst encodings are the incrementing ones (INCR, INCR4/8/16).
    assign kb_cross_o = burst_i[0] && (incr_addr[ADDR_WIDTH-1:10] != addr_i[ADDR_WIDTH-1:10]);
`else
    assign kb_cross_o = 1'b0;
`endif

endmodule

// File: rtl/ahb_burst_addr_gen.sv
// AHB master address-phase sequencer: one sanitised burst command in, HTRANS/HADDR beats out.
// Optional 1 KB burst splitting is compiled in with AHB_KB_BOUNDARY_EN (see ahb_addr_step).
module ahb_burst_addr_gen
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_INCR_LEN = 16,
    parameter int LEN_W        = $clog2(MAX_INCR_LEN) + 1
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    ahb_burst_addr_gen_if.master bus
);
    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));
    localparam int         BW       = (LEN_W > 5) ? LEN_W : 5;
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [0:0]            state_q,    state_d;
    logic [ADDR_WIDTH-1:0] haddr_q,    haddr_d;
    logic [2:0]            hburst_q,   hburst_d;
    logic [2:0]            hsize_q,    hsize_d;
    logic                  hwrite_q,   hwrite_d;
    logic [1:0]            htrans_q,   htrans_d;
    logic [BW-1:0]         beats_q,    beats_d;
    logic [BW-1:0]         beat_idx_q, beat_idx_d;
    logic                  err_q,      err_d;

    logic [2:0]            size_s;
    logic [BW-1:0]         beats_s;
    logic [ADDR_WIDTH-1:0] addr_s;
    logic                  size_err, len_err;
    logic                  last_beat, cmd_ready, accept;
    logic [ADDR_WIDTH-1:0] step_addr;
    logic                  kb_cross;

    always_comb begin
        size_s   = bus.cmd_size;
        size_err = 1'b0;
        if (bus.cmd_size > MAX_SIZE) begin
            size_s   = MAX_SIZE;
            size_err = 1'b1;
        end
        beats_s = BW'(get_burst_size(bus.cmd_burst));
        len_err = 1'b0;
        if (bus.cmd_burst == AHB_BURST_INCR) begin
            if (bus.cmd_len == '0) begin
                beats_s = BW'(1);
                len_err = 1'b1;
            end else if (BW'(bus.cmd_len) > BW'(MAX_INCR_LEN)) begin
                beats_s = BW'(MAX_INCR_LEN);
                len_err = 1'b1;
            end else begin
                beats_s = BW'(bus.cmd_len);
            end
        end
    end

    assign addr_s    = bus.cmd_addr & ~((ADDR_WIDTH'(1) << size_s) - ADDR_WIDTH'(1));
    assign last_beat = (state_q == ST_ACTIVE) && (beat_idx_q == beats_q - BW'(1));
    assign cmd_ready = (state_q == ST_IDLE) || (last_beat && bus.HREADY);
    assign accept    = bus.cmd_valid && cmd_ready;

    ahb_addr_step #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_step (
        .addr_i      (haddr_q),
        .size_i      (hsize_q),
        .burst_i     (hburst_q),
        .next_addr_o (step_addr),
        .kb_cross_o  (kb_cross)
    );

    always_comb begin
        state_d    = state_q;
        haddr_d    = haddr_q;
        hburst_d   = hburst_q;
        hsize_d    = hsize_q;
        hwrite_d   = hwrite_q;
        htrans_d   = htrans_q;
        beats_d    = beats_q;
        beat_idx_d = beat_idx_q;
        err_d      = 1'b0;
        if (accept) begin
            state_d    = ST_ACTIVE;
            haddr_d    = addr_s;
            hburst_d   = bus.cmd_burst;
            hsize_d    = size_s;
            hwrite_d   = bus.cmd_write;
            htrans_d   = AHB_TRANS_NONSEQ;
            beats_d    = beats_s;
            beat_idx_d = '0;
            err_d      = size_err || len_err;
        end else if ((state_q == ST_ACTIVE) && bus.HREADY) begin
            if (last_beat) begin
                // Address/control are left as-is so the bus keeps a stable idle address.
                state_d    = ST_IDLE;
                htrans_d   = AHB_TRANS_IDLE;
                beat_idx_d = '0;
            end else begin
                haddr_d    = step_addr;
                beat_idx_d = beat_idx_q + BW'(1);
                htrans_d   = AHB_TRANS_SEQ;
                if (kb_cross) begin
                    htrans_d = AHB_TRANS_NONSEQ;
                    hburst_d = AHB_BURST_INCR;
                end
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= ST_IDLE;
            haddr_q    <= '0;
            hburst_q   <= '0;
            hsize_q    <= '0;
            hwrite_q   <= 1'b0;
            htrans_q   <= AHB_TRANS_IDLE;
            beats_q    <= '0;
            beat_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            haddr_q    <= haddr_d;
            hburst_q   <= hburst_d;
            hsize_q    <= hsize_d;
            hwrite_q   <= hwrite_d;
            htrans_q   <= htrans_d;
            beats_q    <= beats_d;
            beat_idx_q <= beat_idx_d;
            err_q      <= err_d;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.HTRANS    = htrans_q;
    assign bus.HADDR     = haddr_q;
    assign bus.HBURST    = hburst_q;
    assign bus.HSIZE     = hsize_q;
    assign bus.HWRITE    = hwrite_q;
    assign bus.beat_idx  = LEN_W'(beat_idx_q);
    assign bus.last_beat = last_beat;
    assign bus.cmd_err   = err_q;

endmodule
